complex_divider: RTL and testbench
==================================

Name: complex_divider

Overview:
- Sequential complex divider; the inverse of the complex multiplier stage.
- Takes a packed complex product (two 17-bit two's-complement parts) and a packed complex divisor (two 8-bit parts). Returns the packed 8-bit complex quotient.
- Computes Q = N / D = ((x·c + y·d) + j(y·c − x·d)) / (c² + d²), using two parallel restoring dividers run by an FSM.
- Uses valid/ready handshake on both sides and sits directly downstream of the multiplier output register.

Parameters:
- PART_W, 8: width of each divisor and quotient part, signed.
- NUM_W, 17: width of each dividend part, signed.
- Only the defaults are verified. All widths below are stated for the defaults.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Dividend  in  34  {real[33:17], imag[16:0]}, two's complement; same packing as the multiplier result.
- Divisor  in  16  {c[15:8], d[7:0]}, two's complement.
- InValid  in  1  Dividend and Divisor are valid.
- InReady  out  1  block can accept an operation.
- Quotient  out  16  {qr[15:8], qi[7:0]}, two's complement.
- DivByZero  out  1  the divisor of the current result was 0+j0.
- OutValid  out  1  Quotient and DivByZero are valid.
- OutReady  in  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, active-low) and its outputs:
  - Any reset, including mid-operation, aborts the operation and returns the FSM to IDLE.
  - Quotient=0, DivByZero=0, OutValid=0.
  - InReady = (state==IDLE), so it reads 1 during reset.
- States: IDLE → PREP → DIV → FIN → DONE → IDLE.
- Edge E0, in IDLE: if InValid and InReady are both 1, capture Dividend and Divisor, go to PREP. Inputs are ignored in every other state.
- Edge E1, in PREP: register the following, then clear the iteration counter and go to DIV.
  - Pr = x·c + y·d and Pi = y·c − x·d, both 26-bit signed.
  - M = c² + d², 16-bit unsigned, maximum 32768.
  - Sign bits of Pr and Pi.
  - |Pr| and |Pi|, 25-bit unsigned.
  - Zero flag Z = (M==0).
- Edges E2..E26, in DIV: one restoring step per edge for both dividers in parallel, 25 iterations.
  - Remainder width is 17 bits.
  - After the 25th iteration go to FIN.
- Edge E27, in FIN:
  - Apply the sign to each magnitude quotient, truncating toward zero.
  - Saturate each part to [−128, 127].
  - If Z=1: Quotient=0x0000, DivByZero=1; otherwise DivByZero=0.
  - Set OutValid=1 and go to DONE.
- Latency is fixed: OutValid rises 27 edges after the acceptance edge, regardless of operands or Z.
- DONE:
  - Hold Quotient, DivByZero and OutValid stable while OutReady=0.
  - On an edge with OutReady=1: OutValid←0, go to IDLE. InReady is 1 in the following cycle.
  - Quotient keeps its last value after the handshake.
- Throughput is at most one operation per 29 cycles. There is no overlap of operations.
- Remainders are discarded. Divide by zero never raises X and never stalls.

Test Plan:
- Basic divide: Dividend=0x00004000B (2+j11), Divisor=0x0201 (2+j1) → Quotient=0x0304 (3+j4), DivByZero=0, OutValid exactly 27 edges after accept.
- Signs: Dividend = {−2, 11} packed = 0x3FFFC000B, Divisor=0x02FF (2−j1) → Quotient=0xFD04 (−3+j4).
- Truncation toward zero:
  - Dividend = {7, 0}, Divisor=0x0200 → Quotient=0x0300.
  - Dividend = {−7, 0}, Divisor=0x0200 → Quotient=0xFD00.
- Saturation:
  - Dividend = {1000, 0}, Divisor=0x0100 → Quotient=0x7F00.
  - Dividend = {−1000, 0}, Divisor=0x0100 → Quotient=0x8000.
- Divide by zero: any Dividend with Divisor=0x0000 → Quotient=0x0000, DivByZero=1, same 27-edge latency. The next operation clears DivByZero.
- Handshake and reset:
  - Hold OutReady=0 for 5 cycles after OutValid → outputs stable and InReady=0; the handshake edge returns the block to IDLE.
  - InValid held high during DIV is ignored.
  - Reset pulled low at iteration 10 → OutValid=0, Quotient=0 immediately; after release, a new operation completes correctly.

Source files
------------

// File: rtl/complex_divider.sv
// Sequential complex divider: Q = N / D for a packed 17-bit complex dividend and an
// 8-bit complex divisor, using two parallel restoring dividers sequenced by an FSM.
module complex_divider #(
  parameter int PART_W = 8,
  parameter int NUM_W  = 17
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [2*NUM_W-1:0]    Dividend,
  input  logic [2*PART_W-1:0]   Divisor,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [2*PART_W-1:0]   Quotient,
  output logic                  DivByZero,
  output logic                  OutValid,
  input  logic                  OutReady
);

  localparam int PROD_W = NUM_W + PART_W + 1;  // signed x*c + y*d
  localparam int MAG_W  = PROD_W - 1;          // |Pr|, |Pi| and quotient magnitude
  localparam int M_W    = 2 * PART_W;          // c^2 + d^2
  localparam int REM_W  = M_W + 1;
  localparam int CNT_W  = $clog2(MAG_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAG_W - 1);

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIN, DONE} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [NUM_W-1:0]   x, y;
  logic signed [PART_W-1:0]  c, d;
  logic [M_W-1:0]            m;
  logic                      z, neg_r, neg_i;
  logic [MAG_W-1:0]          num_r, num_i;
  logic [REM_W-1:0]          rem_r, rem_i;

  logic signed [PROD_W-1:0]  pr_c, pi_c;
  logic [M_W-1:0]            m_c;
  logic [MAG_W-1:0]          pr_mag, pi_mag;
  logic [MAG_W-1:0]          num_r_nx, num_i_nx;
  logic [REM_W-1:0]          rem_r_nx, rem_i_nx;

  // One restoring step; the quotient bit shifts into the LSB of the numerator register.
  function automatic logic [REM_W+MAG_W-1:0] div_step(
    input logic [REM_W-1:0] rem,
    input logic [MAG_W-1:0] num,
    input logic [M_W-1:0]   dv
  );
    logic [REM_W-1:0] sh;
    logic             ge;
    sh = {rem[REM_W-2:0], num[MAG_W-1]};
    ge = (sh >= {1'b0, dv});
    return {(ge ? sh - {1'b0, dv} : sh), num[MAG_W-2:0], ge};
  endfunction

  function automatic logic [PART_W-1:0] sat(
    input logic             neg,
    input logic [MAG_W-1:0] q
  );
    if (neg)
      return (q > MAG_W'(2**(PART_W-1))) ? {1'b1, {(PART_W-1){1'b0}}} : PART_W'(-q);
    else
      return (q > MAG_W'(2**(PART_W-1) - 1)) ? {1'b0, {(PART_W-1){1'b1}}} : q[PART_W-1:0];
  endfunction

  // Low-order bits of a product are signedness-independent, so sized casts suffice.
  always_comb begin
    pr_c   = signed'(PROD_W'(x)) * signed'(PROD_W'(c)) + signed'(PROD_W'(y)) * signed'(PROD_W'(d));
    pi_c   = signed'(PROD_W'(y)) * signed'(PROD_W'(c)) - signed'(PROD_W'(x)) * signed'(PROD_W'(d));
    m_c    = M_W'(signed'(M_W'(c)) * signed'(M_W'(c))) + M_W'(signed'(M_W'(d)) * signed'(M_W'(d)));
    pr_mag = pr_c[PROD_W-1] ? MAG_W'(-pr_c) : MAG_W'(pr_c);
    pi_mag = pi_c[PROD_W-1] ? MAG_W'(-pi_c) : MAG_W'(pi_c);
    {rem_r_nx, num_r_nx} = div_step(rem_r, num_r, m);
    {rem_i_nx, num_i_nx} = div_step(rem_i, num_i, m);
  end

  assign InReady = (state == IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      c         <= '0;
      d         <= '0;
      m         <= '0;
      z         <= 1'b0;
      neg_r     <= 1'b0;
      neg_i     <= 1'b0;
      num_r     <= '0;
      num_i     <= '0;
      rem_r     <= '0;
      rem_i     <= '0;
      Quotient  <= '0;
      DivByZero <= 1'b0;
      OutValid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            x     <= Dividend[2*NUM_W-1:NUM_W];
            y     <= Dividend[NUM_W-1:0];
            c     <= Divisor[2*PART_W-1:PART_W];
            d     <= Divisor[PART_W-1:0];
            state <= PREP;
          end
        end
        PREP: begin
          num_r <= pr_mag;
          num_i <= pi_mag;
          neg_r <= pr_c[PROD_W-1];
          neg_i <= pi_c[PROD_W-1];
          m     <= m_c;
          z     <= (m_c == '0);
          rem_r <= '0;
          rem_i <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          num_r <= num_r_nx;
          num_i <= num_i_nx;
          rem_r <= rem_r_nx;
          rem_i <= rem_i_nx;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER)
            state <= FIN;
        end
        FIN: begin
          if (z) begin
            Quotient  <= '0;
            DivByZero <= 1'b1;
          end else begin
            Quotient  <= {sat(neg_r, num_r), sat(neg_i, num_i)};
            DivByZero <= 1'b0;
          end
          OutValid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// Directed bench for complex_divider: driver pushes expected results into a queue,
// a negedge monitor pops and checks value, DivByZero, latency and handshake behaviour.
module tb_complex_divider;

  logic        Clk;
  logic        Reset;
  logic [33:0] Dividend;
  logic [15:0] Divisor;
  logic        InValid;
  logic        InReady;
  logic [15:0] Quotient;
  logic        DivByZero;
  logic        OutValid;
  logic        OutReady;

  complex_divider #(.PART_W(8), .NUM_W(17)) dut (
    .Clk(Clk), .Reset(Reset), .Dividend(Dividend), .Divisor(Divisor),
    .InValid(InValid), .InReady(InReady), .Quotient(Quotient),
    .DivByZero(DivByZero), .OutValid(OutValid), .OutReady(OutReady)
  );

  typedef struct {
    logic [15:0] q;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   active;
  bit   have_cur;
  int   checks;
  int   failures;
  int   cyc;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [33:0] pk(input int r, input int i);
    return {r[16:0], i[16:0]};
  endfunction

  function automatic logic [15:0] pd(input int a, input int b);
    return {a[7:0], b[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: first valid cycle pops an expectation; every valid cycle re-checks it.
  always @(negedge Clk) begin
    if (Reset && OutValid) begin
      if (!active) begin
        active = 1'b1;
        if (sb.size() == 0) begin
          have_cur = 1'b0;
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          check("latency", 32'(cyc - cur.acc), 32'd27);
        end
      end
      if (have_cur) begin
        check("quotient", 32'(Quotient), 32'(cur.q));
        check("divbyzero", 32'(DivByZero), 32'(cur.dbz));
      end
      check("inready_busy", 32'(InReady), 32'd0);
    end else if (active && !OutValid) begin
      active = 1'b0;
      check("inready_after_hs", 32'(InReady), 32'd1);
    end
  end

  task automatic issue(input logic [33:0] dv, input logic [15:0] ds);
    int n;
    n = 0;
    @(negedge Clk);
    while (!InReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("inready_wait", 32'(InReady), 32'd1);
    Dividend = dv;
    Divisor  = ds;
    InValid  = 1'b1;
  endtask

  task automatic run_op(input logic [33:0] dv, input logic [15:0] ds,
                        input logic [15:0] eq, input logic edbz,
                        input int hold, input bit keep);
    int n;
    issue(dv, ds);
    sb.push_back('{q: eq, dbz: edbz, acc: cyc + 1});
    @(negedge Clk);
    if (keep) begin
      repeat (5) @(negedge Clk);
      Dividend = pk(1, 1);
      Divisor  = 16'h0100;
    end else begin
      InValid = 1'b0;
    end
    n = 0;
    while (!OutValid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    InValid = 1'b0;
    if (!OutValid) begin
      check("outvalid_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (hold) @(negedge Clk);
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    active   = 1'b0;
    have_cur = 1'b0;
    Reset    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_quotient", 32'(Quotient), 32'd0);
    check("rst_divbyzero", 32'(DivByZero), 32'd0);
    Reset = 1'b1;

    run_op(pk(2, 11),      pd(2, 1),       16'h0304, 1'b0, 0, 1'b0);
    run_op(pk(-2, 11),     pd(2, -1),      16'hFD04, 1'b0, 0, 1'b0);
    run_op(pk(7, 0),       pd(2, 0),       16'h0300, 1'b0, 5, 1'b0);
    run_op(pk(-7, 0),      pd(2, 0),       16'hFD00, 1'b0, 0, 1'b0);
    run_op(pk(1000, 0),    pd(1, 0),       16'h7F00, 1'b0, 1, 1'b0);
    run_op(pk(-1000, 0),   pd(1, 0),       16'h8000, 1'b0, 0, 1'b0);
    run_op(pk(2, 11),      16'h0000,       16'h0000, 1'b1, 2, 1'b0);
    run_op(pk(2, 11),      pd(2, 1),       16'h0304, 1'b0, 0, 1'b0);
    run_op(pk(-65536, -65536), pd(-128, -128), 16'h7F00, 1'b0, 0, 1'b0);
    run_op(pk(100, -50),   pd(3, 4),       16'h04EA, 1'b0, 0, 1'b1);

    // Abort mid-division: accept edge A, iteration 10 completes on edge A+11.
    issue(pk(-100, -60), pd(-5, 3));
    @(negedge Clk);
    InValid = 1'b0;
    repeat (11) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("abort_outvalid", 32'(OutValid), 32'd0);
    check("abort_quotient", 32'(Quotient), 32'd0);
    check("abort_inready", 32'(InReady), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;

    run_op(pk(-100, -60),  pd(-5, 3),      16'h0911, 1'b0, 0, 1'b0);

    repeat (5) @(negedge Clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
